xc_sync_fifo_lvl: RTL and testbench
===================================

Name: xc_sync_fifo_lvl

Overview:
Parametrised successor to the team's single-clock record FIFO.
- Supports any DEPTH, not only powers of two.
- Adds an explicit fill-level output and sticky overflow/underflow error flags.
- Write is accepted while full if a read happens in the same cycle.
- Sits between SPI shift logic and the register/bus interface as the generic receive and transmit buffer.

Parameters:
WIDTH, 32, data word width in bits.
DEPTH, 6, number of entries; legal range 2 .. 2**LOG2_DEPTH.
LOG2_DEPTH, 3, pointer width, ceil(log2(DEPTH)); level and threshold width is LOG2_DEPTH+1 (LVL_W).

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous reset, active-high.
clr_i  in  1  synchronous clear: pointers, level, storage and error flags.
err_clr_i  in  1  synchronous clear of ovf_o and udf_o only.
wr_i  in  1  write request.
data_i  in  WIDTH  write data.
rd_i  in  1  read request; pops the head word.
data_o  out  WIDTH  head word (show-ahead); valid when ne_o=1.
ne_o  out  1  not empty.
full_o  out  1  level == DEPTH.
level_o  out  LVL_W  current number of stored words, 0..DEPTH.
af_count_i  in  LVL_W  almost-full threshold.
ae_count_i  in  LVL_W  almost-empty threshold.
af_o  out  1  level_o >= af_count_i.
ae_o  out  1  level_o <= ae_count_i.
ovf_o  out  1  sticky: write dropped.
udf_o  out  1  sticky: read while empty.
peak_o  out  LVL_W  high-water mark (see Optional Feature).

Behaviour:
- Reset (async, rst_i=1):
  - rd_ptr, wr_ptr and level are 0; all storage is 0.
  - ovf_o=0, udf_o=0, peak_o=0.
  - Resulting outputs: ne_o=0, full_o=0, data_o=0, af_o=(af_count_i==0), ae_o=1.
- Priority: rst_i > clr_i > normal operation. clr_i has the same effect as reset, one cycle later. err_clr_i is ignored when clr_i=1, since clr_i already clears the flags.
- Read accept: rd_ok = rd_i & ne_o.
- Write accept: wr_ok = wr_i & (~full_o | rd_ok). A write into a full FIFO with a simultaneous valid read is accepted.
- Pointers: each advances by 1 on its accept and wraps from DEPTH-1 to 0 (modulo DEPTH, valid for non-power-of-2 DEPTH).
- Level update per cycle:
  - wr_ok only: +1.
  - rd_ok only: -1.
  - both or neither: unchanged.
  - Level never leaves the range 0..DEPTH.
- Status outputs are combinational from registered state: ne_o=(level!=0), full_o=(level==DEPTH). af_o and ae_o are compared against the live threshold inputs.
- Latency:
  - A write is visible on data_o and ne_o in the cycle after acceptance (write-to-read latency 1).
  - After a read, data_o shows the next word on the following cycle.
  - A simultaneous read and write on an empty FIFO: the read is rejected (udf) and the write is accepted.
- Overflow: wr_i & full_o & ~rd_ok sets ovf_o the next cycle. The data is dropped and no state changes.
- Underflow: rd_i & ~ne_o sets udf_o the next cycle. Pointers and level are unchanged.
- Error flags: once set, they stay set until err_clr_i, clr_i or rst_i. If err_clr_i and a new error occur in the same cycle, the error wins and the flag stays 1.
- Storage is written only on wr_ok, at wr_ptr. data_o = mem[rd_ptr], read without a register.

Optional Feature:
Macro XC_SYNC_FIFO_PEAK_EN.
- Defined:
  - peak_o is a register holding the maximum level_o since the last rst_i, clr_i or err_clr_i.
  - It updates to the new level on the cycle the level exceeds it.
  - err_clr_i resets it to the current level.
- Undefined: peak_o is tied to 0 and no register is generated. The port is always present.

Decomposition:
- Shared package xc_fifo_pkg:
  - clog2 function.
  - LVL_W derivation.
  - Status-bit index constants for register-map packing: NE, FULL, AF, AE, OVF, UDF.
- One sub-module xc_fifo_ptr: modulo-DEPTH wrapping counter with enable and synchronous clear. Instantiated twice, once for rd_ptr and once for wr_ptr.

Test Plan (DEPTH=6, WIDTH=8):
- Reset with af=5, ae=1 -> level_o=0, ne_o=0, full_o=0, ae_o=1, af_o=0, ovf_o=udf_o=0.
- Write 0x11..0x16 on 6 consecutive cycles -> full_o=1, level_o=6, af_o=1 from level 5. A 7th write (0x77) -> ovf_o=1, level_o stays 6, data_o stays 0x11.
- While full: wr_i=rd_i=1 with 0x88 -> level_o stays 6. Drain 6 reads -> 0x12..0x16 then 0x88. Confirms wrap 5->0 on both pointers.
- Read while empty -> udf_o=1, level_o=0. Then err_clr_i -> udf_o=0. Then err_clr_i plus a read while empty in the same cycle -> udf_o stays 1.
- Write 3 words, assert clr_i together with wr_i -> next cycle level_o=0, ne_o=0, data_o=0, and the write is ignored.
- Macro defined: fill to 4, drain to 1 -> peak_o=4. Then err_clr_i -> peak_o=1. Assert rst_i mid-burst -> every output returns to its reset value immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/xc_fifo_pkg.sv
// Shared definitions for the xc FIFO family: width helpers and the status-bit
// positions used when packing FIFO status into a register-map word.
package xc_fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Level/threshold width: one extra bit so DEPTH itself is representable.
    function automatic int lvl_w(input int log2_depth);
        return log2_depth + 1;
    endfunction

    localparam int ST_NE   = 0;
    localparam int ST_FULL = 1;
    localparam int ST_AF   = 2;
    localparam int ST_AE   = 3;
    localparam int ST_OVF  = 4;
    localparam int ST_UDF  = 5;
    localparam int ST_W    = 6;

endpackage

// File: rtl/xc_fifo_ptr.sv
// Modulo-DEPTH wrapping pointer with enable and synchronous clear; works for
// any DEPTH, not only powers of two.
module xc_fifo_ptr
    import xc_fifo_pkg::*;
#(
    parameter int DEPTH = 6,
    parameter int PTR_W = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/xc_sync_fifo_lvl.sv
// Single-clock show-ahead FIFO with fill level, thresholds and sticky error flags.
// Optional high-water mark on peak_o when XC_SYNC_FIFO_PEAK_EN is defined.
module xc_sync_fifo_lvl
    import xc_fifo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 6,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  err_clr_i,
    input  logic                  wr_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  rd_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  ne_o,
    output logic                  full_o,
    output logic [LOG2_DEPTH:0]   level_o,
    input  logic [LOG2_DEPTH:0]   af_count_i,
    input  logic [LOG2_DEPTH:0]   ae_count_i,
    output logic                  af_o,
    output logic                  ae_o,
    output logic                  ovf_o,
    output logic                  udf_o,
    output logic [LOG2_DEPTH:0]   peak_o
);

    localparam int LVL_W = lvl_w(LOG2_DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LVL_W-1:0]      level_q;
    logic [LVL_W-1:0]      level_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic                  udf_q;
    logic                  udf_d;
    logic [ST_W-1:0]       status;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  wr_drop;
    logic                  rd_bad;

    assign status[ST_NE]   = (level_q != '0);
    assign status[ST_FULL] = (level_q == LVL_W'(DEPTH));
    assign status[ST_AF]   = (level_q >= af_count_i);
    assign status[ST_AE]   = (level_q <= ae_count_i);
    assign status[ST_OVF]  = ovf_q;
    assign status[ST_UDF]  = udf_q;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a write.
    assign rd_ok   = rd_i & status[ST_NE];
    assign wr_ok   = wr_i & (~status[ST_FULL] | rd_ok);
    assign wr_drop = wr_i & status[ST_FULL] & ~rd_ok;
    assign rd_bad  = rd_i & ~status[ST_NE];

    xc_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(LOG2_DEPTH)) u_rd_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .en_i  (rd_ok),
        .ptr_o (rd_ptr)
    );

    xc_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(LOG2_DEPTH)) u_wr_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .en_i  (wr_ok),
        .ptr_o (wr_ptr)
    );

    always_comb begin
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (clr_i) begin
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wr_ok && !rd_ok) begin
                level_d = level_q + LVL_W'(1);
            end else if (rd_ok && !wr_ok) begin
                level_d = level_q - LVL_W'(1);
            end
            // A fresh error outranks a simultaneous flag clear.
            if (wr_drop) begin
                ovf_d = 1'b1;
            end else if (err_clr_i) begin
                ovf_d = 1'b0;
            end
            if (rd_bad) begin
                udf_d = 1'b1;
            end else if (err_clr_i) begin
                udf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_ptr] <= data_i;
        end
    end

`ifdef XC_SYNC_FIFO_PEAK_EN
    logic [LVL_W-1:0] peak_q;
    logic [LVL_W-1:0] peak_d;

    // Tracks the post-update level so peak_o never lags level_o.
    always_comb begin
        peak_d = peak_q;
        if (clr_i) begin
            peak_d = '0;
        end else if (err_clr_i) begin
            peak_d = level_d;
        end else if (level_d > peak_q) begin
            peak_d = level_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_o = peak_q;
`else
    assign peak_o = '0;
`endif

    assign data_o  = mem_q[rd_ptr];
    assign level_o = level_q;
    assign ne_o    = status[ST_NE];
    assign full_o  = status[ST_FULL];
    assign af_o    = status[ST_AF];
    assign ae_o    = status[ST_AE];
    assign ovf_o   = status[ST_OVF];
    assign udf_o   = status[ST_UDF];

endmodule

// File: tb/tb_xc_sync_fifo_lvl.sv
// Directed bench for xc_sync_fifo_lvl at DEPTH=6, WIDTH=8; peak_o expectations
// follow XC_SYNC_FIFO_PEAK_EN.
module tb_xc_sync_fifo_lvl;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 6;
    localparam int LOG2_DEPTH = 3;

    logic                clk;
    logic                rst;
    logic                clr;
    logic                err_clr;
    logic                wr;
    logic [WIDTH-1:0]    din;
    logic                rd;
    logic [WIDTH-1:0]    dout;
    logic                ne;
    logic                full;
    logic [LOG2_DEPTH:0] level;
    logic [LOG2_DEPTH:0] af_count;
    logic [LOG2_DEPTH:0] ae_count;
    logic                af;
    logic                ae;
    logic                ovf;
    logic                udf;
    logic [LOG2_DEPTH:0] peak;

    int n_run;
    int n_fail;

    xc_sync_fifo_lvl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LOG2_DEPTH(LOG2_DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (clr),
        .err_clr_i  (err_clr),
        .wr_i       (wr),
        .data_i     (din),
        .rd_i       (rd),
        .data_o     (dout),
        .ne_o       (ne),
        .full_o     (full),
        .level_o    (level),
        .af_count_i (af_count),
        .ae_count_i (ae_count),
        .af_o       (af),
        .ae_o       (ae),
        .ovf_o      (ovf),
        .udf_o      (udf),
        .peak_o     (peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_ne"},    32'(ne),    0);
        chk({tag, "_full"},  32'(full),  0);
        chk({tag, "_data"},  32'(dout),  0);
        chk({tag, "_ae"},    32'(ae),    1);
        chk({tag, "_af"},    32'(af),    0);
        chk({tag, "_ovf"},   32'(ovf),   0);
        chk({tag, "_udf"},   32'(udf),   0);
        chk({tag, "_peak"},  32'(peak),  0);
    endtask

    initial begin
        logic [7:0] drain_exp [6];
        int         peak_en;
        n_run    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clr      = 1'b0;
        err_clr  = 1'b0;
        wr       = 1'b0;
        rd       = 1'b0;
        din      = '0;
        af_count = 4'd5;
        ae_count = 4'd1;
`ifdef XC_SYNC_FIFO_PEAK_EN
        peak_en = 1;
`else
        peak_en = 0;
`endif
        drain_exp[0] = 8'h12; drain_exp[1] = 8'h13; drain_exp[2] = 8'h14;
        drain_exp[3] = 8'h15; drain_exp[4] = 8'h16; drain_exp[5] = 8'h88;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1'b0;

        // Fill to full
        for (int i = 0; i < DEPTH; i++) begin
            wr  = 1'b1;
            din = 8'h11 + 8'(i);
            tick();
            chk("fill_level", 32'(level), 32'(i + 1));
            chk("fill_af",    32'(af),    32'((i + 1) >= 5));
            chk("fill_ae",    32'(ae),    32'((i + 1) <= 1));
            chk("fill_full",  32'(full),  32'(i == DEPTH - 1));
        end
        chk("full_head", 32'(dout), 32'h11);

        // Write while full: dropped
        din = 8'h77;
        tick();
        chk("ovf_set",   32'(ovf),   1);
        chk("ovf_level", 32'(level), 6);
        chk("ovf_head",  32'(dout),  32'h11);

        // Simultaneous read and write while full
        rd  = 1'b1;
        din = 8'h88;
        tick();
        chk("rw_full_level", 32'(level), 6);
        chk("rw_full_full",  32'(full),  1);

        // Drain across pointer wrap
        wr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_data", 32'(dout), 32'(drain_exp[i]));
            tick();
            chk("drain_level", 32'(level), 32'(DEPTH - 1 - i));
        end
        chk("drained_ne", 32'(ne), 0);

        // Underflow and error clear
        tick();
        rd = 1'b0;
        chk("udf_set",   32'(udf),   1);
        chk("udf_level", 32'(level), 0);
        err_clr = 1'b1;
        tick();
        chk("errclr_udf", 32'(udf), 0);
        chk("errclr_ovf", 32'(ovf), 0);
        rd = 1'b1;
        tick();
        rd      = 1'b0;
        err_clr = 1'b0;
        chk("udf_wins", 32'(udf), 1);

        // Synchronous clear beats a concurrent write
        wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 8'hA1 + 8'(i);
            tick();
        end
        chk("pre_clr_level", 32'(level), 3);
        chk("pre_clr_head",  32'(dout),  32'hA1);
        clr = 1'b1;
        din = 8'hA4;
        tick();
        clr = 1'b0;
        wr  = 1'b0;
        chk("clr_level", 32'(level), 0);
        chk("clr_ne",    32'(ne),    0);
        chk("clr_data",  32'(dout),  0);
        chk("clr_udf",   32'(udf),   0);
        tick();
        chk("clr_hold_level", 32'(level), 0);

        // High-water mark
        wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 8'hB1 + 8'(i);
            tick();
        end
        wr = 1'b0;
        rd = 1'b1;
        repeat (3) tick();
        rd = 1'b0;
        chk("peak_level", 32'(level), 1);
        chk("peak_head",  32'(dout),  32'hB4);
        chk("peak_max",   32'(peak),  peak_en ? 4 : 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("peak_errclr", 32'(peak), peak_en ? 1 : 0);

        // Asynchronous reset mid-burst
        wr  = 1'b1;
        din = 8'hC1;
        tick();
        din = 8'hC2;
        tick();
        chk("burst_level", 32'(level), 3);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        af_count = 4'd0;
        #1;
        chk("af_zero_thr", 32'(af), 1);
        wr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
